// File: rtl/mips_multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit:
// opcodes, funct codes, ALU codes, FSM states and the control bundle.
package mips_multicycle_ctrl_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC     = 4'd6,
    S_RTWB     = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [2:0] alu_ctrl;
    logic       instr_done;
  } ctl_t;

  function automatic ctl_t ctl_idle();
    ctl_t c;
    c = '0;
    c.alu_ctrl = ALU_ADD;
    return c;
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_alu_decode.sv
// Funct field to ALU operation code, with a flag
// marking funct values the core implements.
module mips_multicycle_ctrl_alu_decode
  import mips_multicycle_ctrl_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] code,
  output logic       valid
);

  always_comb begin
    code  = ALU_ADD;
    valid = 1'b1;
    unique case (1'b1)
      (funct == FN_ADD): code = ALU_ADD;
      (funct == FN_SUB): code = ALU_SUB;
      (funct == FN_AND): code = ALU_AND;
      (funct == FN_OR):  code = ALU_OR;
      (funct == FN_SLT): code = ALU_SLT;
      default:           valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch through writeback
// and drives the datapath selects and the ALU operation code.
module mips_multicycle_ctrl
  import mips_multicycle_ctrl_pkg::*;
#(
  parameter bit EXC_ON_ILLEGAL = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [1:0] PCSource,
  output logic [2:0] AluCtrl,
  output logic       InstrDone,
  output logic       Exception
);

  state_t     state, state_next;
  logic       is_sw, is_sw_next;
  logic [2:0] r_code, r_code_next;
  logic [2:0] dec_code;
  logic       dec_valid;
  logic       exc;
  ctl_t       raw, ctl;

  // Zero feeds the datapath PC-write gate, not this FSM.
  logic unused_zero;
  assign unused_zero = Zero;

  mips_multicycle_ctrl_alu_decode u_dec (
    .funct (Funct),
    .code  (dec_code),
    .valid (dec_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_FETCH;
      is_sw  <= 1'b0;
      r_code <= ALU_ADD;
      exc    <= 1'b0;
    end else begin
      state  <= state_next;
      is_sw  <= is_sw_next;
      r_code <= r_code_next;
      if (state_next == S_TRAP) exc <= 1'b1;
    end
  end

  always_comb begin
    raw         = ctl_idle();
    state_next  = state;
    is_sw_next  = is_sw;
    r_code_next = r_code;
    unique case (state)
      S_FETCH: begin
        raw.mem_read  = 1'b1;
        raw.alu_src_b = 2'b01;
        if (MemReady) begin
          raw.ir_write = 1'b1;
          raw.pc_write = 1'b1;
          state_next   = S_DECODE;
        end
      end
      S_DECODE: begin
        raw.alu_src_b = 2'b11;
        // Opcode/Funct are only trusted here, so latch what later states need.
        is_sw_next  = (Opcode == OP_SW);
        r_code_next = dec_code;
        unique case (1'b1)
          (Opcode == OP_LW) || (Opcode == OP_SW):
            state_next = S_MEMADDR;
          (Opcode == OP_R) && dec_valid:
            state_next = S_EXEC;
          (Opcode == OP_BEQ):
            state_next = S_BRANCH;
          (Opcode == OP_J):
            state_next = S_JUMP;
          (Opcode == OP_ADDI):
            state_next = S_ADDIEX;
          default: begin
            if (EXC_ON_ILLEGAL) begin
              state_next = S_TRAP;
            end else begin
              state_next     = S_FETCH;
              raw.instr_done = 1'b1;
            end
          end
        endcase
      end
      S_MEMADDR: begin
        raw.alu_src_a = 1'b1;
        raw.alu_src_b = 2'b10;
        state_next    = is_sw ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        raw.mem_read = 1'b1;
        raw.i_or_d   = 1'b1;
        if (MemReady) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        raw.reg_write  = 1'b1;
        raw.mem_to_reg = 1'b1;
        raw.instr_done = 1'b1;
        state_next     = S_FETCH;
      end
      S_MEMWRITE: begin
        raw.mem_write = 1'b1;
        raw.i_or_d    = 1'b1;
        if (MemReady) begin
          raw.instr_done = 1'b1;
          state_next     = S_FETCH;
        end
      end
      S_EXEC: begin
        raw.alu_src_a = 1'b1;
        raw.alu_ctrl  = r_code;
        state_next    = S_RTWB;
      end
      S_RTWB: begin
        raw.reg_write  = 1'b1;
        raw.reg_dst    = 1'b1;
        raw.instr_done = 1'b1;
        state_next     = S_FETCH;
      end
      S_BRANCH: begin
        raw.alu_src_a     = 1'b1;
        raw.alu_ctrl      = ALU_SUB;
        raw.pc_write_cond = 1'b1;
        raw.pc_source     = 2'b01;
        raw.instr_done    = 1'b1;
        state_next        = S_FETCH;
      end
      S_JUMP: begin
        raw.pc_write   = 1'b1;
        raw.pc_source  = 2'b10;
        raw.instr_done = 1'b1;
        state_next     = S_FETCH;
      end
      S_ADDIEX: begin
        raw.alu_src_a = 1'b1;
        raw.alu_src_b = 2'b10;
        state_next    = S_ADDIWB;
      end
      S_ADDIWB: begin
        raw.reg_write  = 1'b1;
        raw.instr_done = 1'b1;
        state_next     = S_FETCH;
      end
      S_TRAP: state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
    // Reset kills enables immediately so an abandoned access has no side effect.
    ctl = rst ? ctl_idle() : raw;
  end

  assign PCWrite     = ctl.pc_write;
  assign PCWriteCond = ctl.pc_write_cond;
  assign IorD        = ctl.i_or_d;
  assign MemRead     = ctl.mem_read;
  assign MemWrite    = ctl.mem_write;
  assign IRWrite     = ctl.ir_write;
  assign MemtoReg    = ctl.mem_to_reg;
  assign RegDst      = ctl.reg_dst;
  assign RegWrite    = ctl.reg_write;
  assign AluSrcA     = ctl.alu_src_a;
  assign AluSrcB     = ctl.alu_src_b;
  assign PCSource    = ctl.pc_source;
  assign AluCtrl     = ctl.alu_ctrl;
  assign InstrDone   = ctl.instr_done;
  assign Exception   = exc;

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control unit that drives the ALU and datapath of the multicycle MIPS variant. It sequences each instruction through fetch, decode, execute, memory and writeback states, produces the 3-bit ALU operation code, and consumes the ALU `Zero` flag to resolve `beq`. Memory accesses use a ready handshake, so the unit tolerates wait-state memories. It replaces the combinational main decoder of the monocycle core.

## Interface
- `EXC_ON_ILLEGAL`, default 1: 1 = an illegal opcode or funct enters TRAP; 0 = it is retired as a NOP and the unit returns to FETCH.

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `Opcode`  in  6  IR[31:26], valid from DECODE onward
- `Funct`  in  6  IR[5:0]
- `Zero`  in  1  ALU zero flag
- `MemReady`  in  1  memory completes the current access this cycle
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemtoReg`, `RegDst`, `RegWrite`, `AluSrcA`  out  1 each  datapath controls
- `AluSrcB`  out  2  ALU operand B select: 00 = rt, 01 = 4, 10 = signext imm, 11 = signext imm<<2
- `PCSource`  out  2  PC source select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- `AluCtrl`  out  3  ALU operation code
- `InstrDone`  out  1  one-cycle pulse when an instruction retires
- `Exception`  out  1  sticky; set on entry to TRAP

## Operation
- **Opcodes:** R = 000000, lw = 100011, sw = 101011, beq = 000100, addi = 001000, j = 000010.
- **Funct map:** 100000 → ADD, 100010 → SUB, 100100 → AND, 100101 → OR, 101010 → SLT.
- **ALU codes:** AND = 000, OR = 001, ADD = 010, SUB = 110, SLT = 111.
- **Default outputs:** every control not listed for a state is 0, and `AluCtrl` is ADD.
- **FETCH:** MemRead=1, IorD=0, AluSrcA=0, AluSrcB=01, ADD, PCSource=00. IRWrite and PCWrite are asserted only in the cycle where MemReady=1, and that cycle exits to DECODE. Otherwise the unit stays in FETCH.
- **DECODE:** AluSrcA=0, AluSrcB=11, ADD (branch target into ALUOut). Next state:
  - lw or sw → MEMADDR
  - R with a valid funct → EXEC
  - beq → BRANCH
  - j → JUMP
  - addi → ADDIEX
  - anything else → TRAP, or FETCH with an InstrDone pulse when EXC_ON_ILLEGAL=0
- **MEMADDR:** AluSrcA=1, AluSrcB=10, ADD. Next state is MEMREAD for lw and MEMWRITE for sw.
- **MEMREAD:** MemRead=1, IorD=1. Waits on MemReady, then goes to MEMWB.
- **MEMWB:** RegWrite=1, MemtoReg=1, RegDst=0, InstrDone. Then FETCH.
- **MEMWRITE:** MemWrite=1, IorD=1. Waits on MemReady. InstrDone is pulsed in the ready cycle, then FETCH.
- **EXEC:** AluSrcA=1, AluSrcB=00, AluCtrl is the funct-decoded code. Then RTWB.
- **RTWB:** RegWrite=1, RegDst=1, MemtoReg=0, InstrDone. Then FETCH.
- **BRANCH:** AluSrcA=1, AluSrcB=00, SUB, PCWriteCond=1, PCSource=01, InstrDone. Then FETCH. The datapath writes the PC when PCWriteCond & Zero.
- **JUMP:** PCWrite=1, PCSource=10, InstrDone. Then FETCH.
- **ADDIEX:** AluSrcA=1, AluSrcB=10, ADD. Then ADDIWB.
- **ADDIWB:** RegWrite=1, RegDst=0, MemtoReg=0, InstrDone. Then FETCH.
- **TRAP:** all enables are 0, Exception=1, and the state is held until `rst`.
- **Output style:** Moore outputs decoded from the registered state. MemReady gates only IRWrite/PCWrite in FETCH and InstrDone in MEMWRITE.

## Timing
- **Reset:** with `rst` high at a clock edge, the state becomes FETCH and Exception becomes 0. While `rst` is high, every enable output is forced to 0 and AluCtrl = ADD. This applies mid-instruction too: the instruction is abandoned and there is no partial RegWrite/MemWrite.
- **Cycles per instruction** with MemReady held at 1: j = 3, beq = 3, R = 4, addi = 4, sw = 4, lw = 5. Each low-MemReady cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- **MemReady:** ignored in all states other than FETCH, MEMREAD and MEMWRITE.
- **Sampling:** Opcode and Funct are sampled only in DECODE. Zero is consumed combinationally by the datapath in BRANCH.
- **Encoding:** the state register is 4 bits, with 13 states encoded 0..12 in the order listed above. An unreachable encoding goes to FETCH.

## Structure
- **ALU_def.vh:** holds the ALU code macros, shared with the ALU.
- **ctrl_def.vh:** a new header for the opcode, funct and state encodings.
- **alu_ctrl_decode:** a combinational sub-module mapping Funct to AluCtrl plus a valid flag. DECODE uses the valid flag and EXEC uses the code.

## Test plan
- **add:** Opcode=000000, Funct=100000, MemReady=1 → states FETCH, DECODE, EXEC (AluCtrl=010), RTWB. RegWrite=1 and RegDst=1 in cycle 4, InstrDone in cycle 4.
- **lw with wait states:** MemReady low for 2 cycles in both FETCH and MEMREAD → 9 cycles total, MemtoReg=1 in MEMWB, IRWrite only in the ready cycle.
- **beq:** beq with Zero=1, then with Zero=0 → BRANCH shows AluCtrl=110, PCWriteCond=1, PCSource=01 in both cases. The instruction retires in 3 cycles.
- **Illegal funct:** Opcode=000000, Funct=000111 → TRAP, Exception=1 held for 20 cycles. A `rst` pulse clears it and the next cycle is FETCH. With EXC_ON_ILLEGAL=0 → InstrDone, then FETCH.
- **Reset mid-operation:** `rst` asserted in MEMWRITE while MemReady=0 → MemWrite=0 while `rst` is high, state is FETCH after release.
- **slt, and, or, sw, j, addi:** each produces its AluCtrl code (111, 000, 001) or its AluSrcB/PCSource select values per the Operation section.
